counter_sequencer: RTL



---
 rtl/counter_seq_pkg.sv | 31 +++
 rtl/counter_sequencer_tick_prescaler.sv | 36 +++
 rtl/counter_sequencer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/counter_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_seq_pkg
// Description : Opcode and state encodings shared by the counter sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_seq_pkg;

    typedef enum logic [2:0] {
        OP_NOP          = 3'd0,
        OP_LOAD         = 3'd1,
        OP_SET_LIMIT    = 3'd2,
        OP_SET_PRESCALE = 3'd3,
        OP_START_UP     = 3'd4,
        OP_START_DOWN   = 3'd5,
        OP_PAUSE        = 3'd6,
        OP_STOP         = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Wide all-ones; users slice it down to their own count width.
    localparam logic [63:0] RESET_LIMIT = '1;

endpackage
`default_nettype wire

// File: rtl/counter_sequencer_tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tick_prescaler
// Description : Emits one tick every prescale+1 enabled cycles; owns pc.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  hold,
    input  logic                  clear,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    localparam logic [PRESCALE_W-1:0] c_one = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] r_pc;

    assign tick = enable && !hold && !clear && (r_pc == prescale);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= '0;
        end else if (clear) begin
            r_pc <= '0;
        end else if (enable && !hold) begin
            r_pc <= tick ? '0 : r_pc + c_one;
        end
    end

endmodule
`default_nettype wire

// File: rtl/counter_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : counter_sequencer
// Description : Command-driven up/down counter with limit, prescale and status.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             wrap,
    output logic             err
);

    localparam logic [WIDTH-1:0] c_count_one = WIDTH'(1);

    state_e                r_state, w_state_nxt;
    logic [WIDTH-1:0]      r_count, w_count_nxt;
    logic [WIDTH-1:0]      r_limit, w_limit_nxt;
    logic [PRESCALE_W-1:0] r_prescale, w_prescale_nxt;
    logic                  r_reload, w_reload_nxt;
    logic                  r_down, w_down_nxt;
    logic                  r_done, w_done_nxt;
    logic                  r_wrap, w_wrap_nxt;
    logic                  r_err, w_err_nxt;

    op_e  w_op;
    logic w_run, w_start, w_pc_clear, w_pc_hold, w_tick, w_at_end;

    assign w_op       = op_e'(cmd_op);
    assign w_run      = (r_state == ST_RUN);
    assign w_start    = cmd_valid && (w_op == OP_START_UP || w_op == OP_START_DOWN);
    // Resuming from PAUSED keeps the partially elapsed prescale interval.
    assign w_pc_clear = (cmd_valid && w_op == OP_STOP) ||
                        (w_start && (r_state == ST_IDLE || r_state == ST_DONE));
    assign w_pc_hold  = cmd_valid && (w_op == OP_PAUSE);
    assign w_at_end   = r_down ? (r_count == '0) : (r_count == r_limit);

    assign cmd_ready = !rst;
    assign count     = r_count;
    assign busy      = w_run;
    assign done      = r_done;
    assign wrap      = r_wrap;
    assign err       = r_err;

    tick_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .enable   (w_run),
        .hold     (w_pc_hold),
        .clear    (w_pc_clear),
        .prescale (r_prescale),
        .tick     (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_limit    <= RESET_LIMIT[WIDTH-1:0];
            r_prescale <= '0;
            r_reload   <= 1'b0;
            r_down     <= 1'b0;
            r_done     <= 1'b0;
            r_wrap     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_limit    <= w_limit_nxt;
            r_prescale <= w_prescale_nxt;
            r_reload   <= w_reload_nxt;
            r_down     <= w_down_nxt;
            r_done     <= w_done_nxt;
            r_wrap     <= w_wrap_nxt;
            r_err      <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_limit_nxt    = r_limit;
        w_prescale_nxt = r_prescale;
        w_reload_nxt   = r_reload;
        w_down_nxt     = r_down;
        w_done_nxt     = 1'b0;
        w_wrap_nxt     = 1'b0;
        w_err_nxt      = 1'b0;

        // Tick acts on the old direction/reload; a same-cycle command layers on top.
        if (w_tick) begin
            if (w_at_end) begin
                if (r_reload) begin
                    w_count_nxt = r_down ? r_limit : '0;
                    w_wrap_nxt  = 1'b1;
                end else begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                end
            end else begin
                w_count_nxt = r_down ? r_count - c_count_one : r_count + c_count_one;
            end
        end

        if (cmd_valid) begin
            case (w_op)
                OP_LOAD: begin
                    if (w_run) w_err_nxt   = 1'b1;
                    else       w_count_nxt = cmd_data;
                end
                OP_SET_LIMIT: begin
                    if (w_run) w_err_nxt   = 1'b1;
                    else       w_limit_nxt = cmd_data;
                end
                OP_SET_PRESCALE: begin
                    if (w_run) w_err_nxt      = 1'b1;
                    else       w_prescale_nxt = cmd_data[PRESCALE_W-1:0];
                end
                OP_START_UP, OP_START_DOWN: begin
                    w_reload_nxt = cmd_data[0];
                    w_down_nxt   = (w_op == OP_START_DOWN);
                    w_state_nxt  = ST_RUN;
                end
                OP_PAUSE: begin
                    if (w_run) w_state_nxt = ST_PAUSED;
                end
                OP_STOP: begin
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
